// File: rtl/simd_mul_fold_if.sv
`default_nettype none
// ============================================================================
// Module      : simd_mul_fold_if
// Description : Operand/result handshake bundle for the SIMD fold multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface simd_mul_fold_if #(
    parameter int VECTOR_WIDTH = 64
);
    localparam int LOG2_VW = $clog2(VECTOR_WIDTH);
    localparam int SEL_W   = $clog2(LOG2_VW + 1);

    logic                      in_valid;
    logic                      in_ready;
    logic [VECTOR_WIDTH-1:0]   in_a;
    logic [VECTOR_WIDTH-1:0]   in_b;
    logic [SEL_W-1:0]          in_sel;
    logic                      out_valid;
    logic                      out_ready;
    logic [2*VECTOR_WIDTH-1:0] out_product;
    logic [SEL_W-1:0]          out_sel;

    modport master (
        output in_valid, in_a, in_b, in_sel, out_ready,
        input  in_ready, out_valid, out_product, out_sel
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, out_ready,
        output in_ready, out_valid, out_product, out_sel
    );
endinterface
`default_nettype wire

// File: rtl/simd_mul_fold.sv
`default_nettype none
// ============================================================================
// Module      : simd_mul_fold
// Description : Sequential SIMD multiplier; folds the bit-level partial-product
//               matrix one level per cycle until the lane width is reached.
//               Optional SIMD_MUL_OVERLAP_EN lets a new accept overlap the
//               output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module simd_mul_fold #(
    parameter int VECTOR_WIDTH = 64
) (
    input  logic           clk,
    input  logic           rst,
    simd_mul_fold_if.slave bus
);
    localparam int LOG2_VW = $clog2(VECTOR_WIDTH);
    localparam int SEL_W   = $clog2(LOG2_VW + 1);
    localparam int VW      = VECTOR_WIDTH;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fold = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_osel;
    logic [2*VW-1:0]  r_prod;
    logic             r_out_valid;

    // Level-L element (I,J) lives in row I*n at bits [J*2n +: 2n], so each
    // fold is an in-place merge of row pairs (r, r+n).
    logic [2*VW-1:0]  r_mat  [VW];
    logic [2*VW-1:0]  w_init [VW];
    logic [2*VW-1:0]  w_lvl  [LOG2_VW][VW];
    logic [2*VW-1:0]  w_fold [VW];
    logic [2*VW-1:0]  w_src  [VW];
    logic [2*VW-1:0]  w_diag [LOG2_VW+1];
    logic [2*VW-1:0]  w_prod;
    logic [SEL_W-1:0] w_sel_clamp;
    logic [SEL_W-1:0] w_level;
    logic [SEL_W-1:0] w_dsel;
    logic             w_in_ready;
    logic             w_accept;

`ifdef SIMD_MUL_OVERLAP_EN
    assign w_in_ready = (r_state == c_st_idle) ||
                        ((r_state == c_st_done) && bus.out_ready);
`else
    assign w_in_ready = (r_state == c_st_idle);
`endif

    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_sel_clamp = (bus.in_sel > SEL_W'(LOG2_VW)) ? SEL_W'(LOG2_VW) : bus.in_sel;
    assign w_level     = r_sel - r_cnt;
    assign w_dsel      = w_accept ? '0 : r_sel;

    always_comb begin
        for (int i = 0; i < VW; i++) begin
            w_init[i] = '0;
            for (int j = 0; j < VW; j++) begin
                w_init[i][2*j] = bus.in_a[i] & bus.in_b[j];
            end
        end
    end

    for (genvar lv = 0; lv < LOG2_VW; lv++) begin : g_lvl
        localparam int c_n = 1 << lv;
        logic [2*VW-1:0]  w_nxt [VW];
        logic [4*c_n-1:0] w_x;
        logic [4*c_n-1:0] w_y;

        // Rows that are not multiples of 2n carry nothing at the next level.
        always_comb begin
            w_x = '0;
            w_y = '0;
            for (int r = 0; r < VW; r++) begin
                w_nxt[r] = '0;
            end
            for (int i = 0; i < VW / (2*c_n); i++) begin
                for (int j = 0; j < VW / (2*c_n); j++) begin
                    w_x = r_mat[2*c_n*i][j*4*c_n +: 4*c_n];
                    w_y = r_mat[2*c_n*i + c_n][j*4*c_n +: 4*c_n];
                    w_nxt[2*c_n*i][j*4*c_n +: 4*c_n] =
                          ({{(2*c_n){1'b0}}, w_y[4*c_n-1 -: 2*c_n]} << (2*c_n))
                        + (({{(2*c_n){1'b0}}, w_y[2*c_n-1:0]}
                          + {{(2*c_n){1'b0}}, w_x[4*c_n-1 -: 2*c_n]}) << c_n)
                        + {{(2*c_n){1'b0}}, w_x[2*c_n-1:0]};
                end
            end
        end

        assign w_lvl[lv] = w_nxt;
    end

    always_comb begin
        w_fold = r_mat;
        for (int lv = 0; lv < LOG2_VW; lv++) begin
            if (w_level == SEL_W'(lv)) begin
                w_fold = w_lvl[lv];
            end
        end
    end

    always_comb begin
        if (w_accept) begin
            w_src = w_init;
        end else begin
            w_src = w_fold;
        end
    end

    for (genvar s = 0; s <= LOG2_VW; s++) begin : g_diag
        localparam int c_e = 1 << s;
        logic [2*VW-1:0] w_d;

        always_comb begin
            w_d = '0;
            for (int k = 0; k < VW / c_e; k++) begin
                w_d[k*2*c_e +: 2*c_e] = w_src[k*c_e][k*2*c_e +: 2*c_e];
            end
        end

        assign w_diag[s] = w_d;
    end

    always_comb begin
        w_prod = w_diag[0];
        for (int s = 0; s <= LOG2_VW; s++) begin
            if (w_dsel == SEL_W'(s)) begin
                w_prod = w_diag[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mat <= w_init;
        end else if (r_state == c_st_fold) begin
            r_mat <= w_fold;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_osel      <= '0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_fold: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == SEL_W'(1)) begin
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                        r_prod      <= w_prod;
                        r_osel      <= r_sel;
                    end
                end
                c_st_done: begin
                    if (bus.out_ready) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b0;
                    end
                end
                c_st_idle: begin
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase

            // A new accept overrides the DONE->IDLE return when overlapping.
            if (w_accept) begin
                r_sel <= w_sel_clamp;
                if (w_sel_clamp == '0) begin
                    r_state     <= c_st_done;
                    r_out_valid <= 1'b1;
                    r_prod      <= w_prod;
                    r_osel      <= '0;
                end else begin
                    r_state <= c_st_fold;
                    r_cnt   <= w_sel_clamp;
                end
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_product = r_prod;
    assign bus.out_sel     = r_osel;
endmodule
`default_nettype wire

// File: tb/tb_simd_mul_fold.sv
`default_nettype none
// ============================================================================
// Module      : tb_simd_mul_fold
// Description : Self-checking bench for simd_mul_fold (16-bit vectors),
//               lane-wise products compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_mul_fold;
    localparam int VW   = 16;
    localparam int LOG2 = 4;
    localparam int SW   = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    simd_mul_fold_if #(.VECTOR_WIDTH(VW)) bus ();

    simd_mul_fold #(.VECTOR_WIDTH(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane-wise unsigned products with lane width 2^min(sel,LOG2).
    function automatic logic [2*VW-1:0] ref_mul(input logic [VW-1:0] a,
                                                input logic [VW-1:0] b,
                                                input int sel);
        int              s;
        int              e;
        longint unsigned la;
        longint unsigned lb;
        longint unsigned mask;
        logic [2*VW-1:0] r;
        s    = (sel > LOG2) ? LOG2 : sel;
        e    = 1 << s;
        mask = (64'd1 << e) - 64'd1;
        r    = '0;
        for (int k = 0; k < VW / e; k++) begin
            la = (64'(a) >> (k*e)) & mask;
            lb = (64'(b) >> (k*e)) & mask;
            r  = r | (2*VW)'((la * lb) << (2*e*k));
        end
        return r;
    endfunction

    // Offers an operation and returns at the falling edge of the cycle after accept.
    task automatic start_op(input logic [VW-1:0] a, input logic [VW-1:0] b,
                            input int sel, input string tag);
        int n;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sel    = SW'(sel);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = VW'($urandom);
        bus.in_b     = VW'($urandom);
        bus.in_sel   = SW'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input int sel, input string tag);
        int              n;
        int              sc;
        logic [2*VW-1:0] exp;
        sc  = (sel > LOG2) ? LOG2 : sel;
        exp = ref_mul(a, b, sel);
        start_op(a, b, sel, tag);
        wait_valid(n);
        check({tag, " latency"}, 64'(n), 64'(sc + 1));
        check({tag, " product"}, 64'(bus.out_product), 64'(exp));
        check({tag, " out_sel"}, 64'(bus.out_sel), 64'(sc));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " valid drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int              n;
        int              got;
        int              idx;
        int              spacing;
        bit              adv;
        int              tstamp [4];
        logic [VW-1:0]   sa [4];
        logic [VW-1:0]   sb [4];
        logic [2*VW-1:0] exp;
        logic [2*VW-1:0] expq [$];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_product", 64'(bus.out_product), 64'd0);
        check("reset out_sel", 64'(bus.out_sel), 64'd0);

        // Directed patterns, including the out-of-range select.
        run_op(16'hFFFF, 16'hFFFF, 4, "full_sel4");
        run_op(16'hFFFF, 16'hFFFF, 3, "ff_sel3");
        run_op(16'h0023, 16'h0045, 2, "sel2");
        run_op(16'h00FF, 16'h00FF, 1, "sel1");
        run_op(16'h00A5, 16'h00FF, 0, "sel0");
        run_op(16'hFFFF, 16'hFFFF, 7, "clamp");

        // Output stall: result and flags hold, new offers are ignored.
        exp = ref_mul(16'hBEEF, 16'h1234, 3);
        start_op(16'hBEEF, 16'h1234, 3, "stall");
        wait_valid(n);
        check("stall latency", 64'(n), 64'd4);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = VW'($urandom);
            bus.in_b     = VW'($urandom);
            bus.in_sel   = '0;
            check("stall out_valid", 64'(bus.out_valid), 64'd1);
            check("stall product", 64'(bus.out_product), 64'(exp));
            check("stall in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("stall release", 64'(bus.out_valid), 64'd0);

        // Reset during the second fold discards the operation.
        start_op(16'hFFFF, 16'hFFFF, 3, "midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst out_product", 64'(bus.out_product), 64'd0);
        check("midrst in_ready", 64'(bus.in_ready), 64'd1);
        repeat (4) @(negedge clk);
        check("midrst no result", 64'(bus.out_valid), 64'd0);
        run_op(16'h1357, 16'h2468, 2, "after_rst");

        for (int t = 0; t < 16; t++) begin
            run_op(VW'($urandom), VW'($urandom), int'($urandom_range(0, 7)), "random");
        end

        // Stream of sel=0 operations with the consumer always ready.
`ifdef SIMD_MUL_OVERLAP_EN
        spacing = 1;
`else
        spacing = 2;
`endif
        for (int i = 0; i < 4; i++) begin
            sa[i] = VW'($urandom);
            sb[i] = VW'($urandom);
        end
        @(posedge clk);
        #1;
        idx           = 0;
        got           = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = sa[0];
        bus.in_b      = sb[0];
        bus.in_sel    = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                exp = (expq.size() > 0) ? expq.pop_front() : '0;
                check("stream product", 64'(bus.out_product), 64'(exp));
                tstamp[got] = c;
                got++;
            end
            adv = bus.in_valid && bus.in_ready;
            if (adv) begin
                expq.push_back(ref_mul(bus.in_a, bus.in_b, 0));
            end
            @(posedge clk);
            #1;
            if (adv) begin
                idx++;
                if (idx < 4) begin
                    bus.in_a = sa[idx];
                    bus.in_b = sb[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        check("stream count", 64'(got), 64'd4);
        for (int i = 1; i < 4; i++) begin
            if (i < got) begin
                check("stream spacing", 64'(tstamp[i] - tstamp[i-1]), 64'(spacing));
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("stream idle", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/simd_mul_fold.md
# simd_mul_fold

Sequential SIMD multiplier that builds the bit-level partial-product matrix of two operand vectors and folds it, one 2x2 block reduction per cycle, until the selected element width is reached. It then presents the diagonal block products as the packed lane-wise product vector. It sits at the input of the SIMD multiply path: the producer of partial-product matrices for the reduction stages and the consumer of their diagonal result. It uses valid/ready handshakes on both sides.

## Interface
- `VECTOR_WIDTH`, 64: operand width in bits; power of two, at least 2.
- `LOG2_VW`, `$clog2(VECTOR_WIDTH)` (localparam): maximum fold count.
- `SEL_W`, `$clog2(LOG2_VW+1)` (localparam): width of the lane-size select.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: block can accept an operation.
- `in_a` input VECTOR_WIDTH: multiplicand vector.
- `in_b` input VECTOR_WIDTH: multiplier vector.
- `in_sel` input SEL_W: log2 of the lane width E (lane width E = 2^sel bits).
- `out_valid` output 1: product vector valid.
- `out_ready` input 1: consumer accepts the product.
- `out_product` output 2*VECTOR_WIDTH: lane k occupies bits `[2E*k +: 2E]` and holds the unsigned product `a_k*b_k`.
- `out_sel` output SEL_W: the clamped sel of the operation being presented.

## Operation
- **States:** IDLE, FOLD, DONE.
- **Accept:** an operation is accepted when `in_valid && in_ready`.
  - `in_a`, `in_b` and `in_sel` are captured.
  - A sel value above LOG2_VW is clamped to LOG2_VW.
- **Level-0 matrix:** `m[i][j] = in_a[i] & in_b[j]`, for 0 ≤ i, j < VECTOR_WIDTH.
  - At level L, element `m[i][j]` is the product of n=2^L-bit chunk i of a and chunk j of b, stored at width 2n.
- **Fold (one per FOLD cycle, L → L+1):**
  - `m'[i][j] = (m[2i+1][2j+1] << 2n) + ((m[2i+1][2j] + m[2i][2j+1]) << n) + m[2i][2j]`.
  - Result width is 4n; no truncation.
  - Only the diagonal blocks must be exact. Off-diagonal storage may be pruned.
- **Transitions:**
  - IDLE → FOLD on accept when sel > 0, with the fold counter loaded to sel.
  - IDLE → DONE on accept when sel = 0; `out_product` lanes are `{1'b0, a_k&b_k}`.
  - FOLD: decrement the counter after each fold; when the last fold completes, go to DONE.
  - DONE: hold `out_product` and `out_sel` stable while `out_valid && !out_ready`. On `out_ready`, go to IDLE.
- **in_ready:** high only in IDLE (see Configuration for the exception).
- **Reset:** takes effect in any state and discards any in-flight operation.
  - State returns to IDLE.
  - `in_ready`=1, `out_valid`=0, `out_product`=0, `out_sel`=0.
  - The fold counter is cleared.

## Timing
- **Latency:** an operation accepted in cycle T has `out_valid` first high in cycle T+1+sel (clamped sel).
  - sel=0 gives 1 cycle; the maximum is LOG2_VW+1 cycles.
- **Throughput (macro off):** one operation per sel+2 cycles, since the DONE→IDLE return costs one cycle.
- **Input hold:** `in_a`, `in_b` and `in_sel` are sampled only in the accept cycle. Changes at other times have no effect.
- **Output handshake:** `out_valid` deasserts in the cycle after the `out_valid && out_ready` handshake, unless a new result is handed off (macro on).
- **rst priority:** `rst` overrides a simultaneous handshake on either side.

## Configuration
- `SIMD_MUL_OVERLAP_EN` defined:
  - `in_ready` is also high in DONE while `out_ready` is high.
  - An accept in the same cycle as the output handshake goes directly to FOLD or DONE with the new operands.
  - This gives back-to-back throughput of one operation per sel+1 cycles, and sel=0 sustains one per cycle.
- `SIMD_MUL_OVERLAP_EN` undefined: `in_ready` = (state == IDLE) exactly.

## Test plan
- VECTOR_WIDTH=8, sel=3, a=0xFF, b=0xFF → `out_product`=0xFE01, `out_valid` in cycle T+4.
- sel=2, a=0x23, b=0x45 → `out_product`=0x080F after 3 cycles. sel=1, a=b=0xFF → 0x9999 after 2 cycles.
- sel=0, a=0xA5, b=0xFF → 0x4411 in cycle T+1. sel=7 (out of range) with a=b=0xFF → `out_sel`=3, result 0xFE01.
- Hold `out_ready`=0 for 5 cycles in DONE → `out_product`/`out_valid` stable; `in_ready`=0; offered `in_valid` ignored.
- Assert `rst` during FOLD (sel=3, second fold) → next cycle IDLE, `out_valid`=0, `out_product`=0; a subsequent operation produces the correct result.
- Macro on: stream of four sel=0 operations with `out_ready`=1 → four results in consecutive cycles. Macro off: results spaced every 2 cycles.
